// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared width constants, state encoding and helpers for the
//                iterative MULT/MULTU unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mult_state_t;

    // Iteration counter width for an arbitrary operand width.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_unit_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_unit_seq_if
//  Description : Request/result bundle between the datapath and the
//                iterative multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_unit_seq_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, op_a, op_b,
        output busy, done, hi, lo
    );

endinterface
`default_nettype wire

// File: rtl/adder_chain_n.sv
`default_nettype none
// ============================================================================
//  Module      : fa4_cell / adder_chain_n
//  Description : Four-bit ripple full-adder cell and a WIDTH-bit chain of
//                those cells used for the partial-sum addition.
//  Revision    : 1.0 - initial release
// ============================================================================
module fa4_cell (
    input  wire logic [3:0] a,
    input  wire logic [3:0] b,
    input  wire logic       cin,
    output logic      [3:0] s,
    output logic            cout
);

    logic [4:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_bit
            assign s[i]     = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_c[4];

endmodule

module adder_chain_n #(
    parameter int WIDTH = 32
) (
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    input  wire logic [WIDTH-1:0] inp0,
    input  wire logic [WIDTH-1:0] inp1,
    input  wire logic             cin
);

    localparam int C_CELLS = WIDTH / 4;

    logic [C_CELLS:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar g = 0; g < C_CELLS; g++) begin : g_cell
            fa4_cell u_cell (
                .a    (inp0[4*g +: 4]),
                .b    (inp1[4*g +: 4]),
                .cin  (w_c[g]),
                .s    (sum[4*g +: 4]),
                .cout (w_c[g+1])
            );
        end
    endgenerate

    assign carry = w_c[C_CELLS];

endmodule
`default_nettype wire

// File: rtl/mult_unit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mult_unit_seq
//  Description : Iterative shift-and-add multiplier for MULT/MULTU producing
//                a 2*WIDTH-bit HI/LO product in WIDTH+1 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_unit_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mult_unit_seq_if.slave   bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    mult_state_t        state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_carry;
    logic               w_acc_top;
    logic [2*WIDTH-1:0] w_prod_raw;
    logic [2*WIDTH-1:0] w_prod;

    // The most-negative operand negates to itself, which is its correct unsigned magnitude.
    assign w_abs_a = (bus.is_signed && bus.op_a[WIDTH-1]) ? (-bus.op_a) : bus.op_a;
    assign w_abs_b = (bus.is_signed && bus.op_b[WIDTH-1]) ? (-bus.op_b) : bus.op_b;

    assign w_addend = mplier_q[0] ? mcand_q : '0;

    adder_chain_n #(
        .WIDTH (WIDTH)
    ) u_adder (
        .sum   (w_sum),
        .carry (w_carry),
        .inp0  (acc_q[WIDTH-1:0]),
        .inp1  (w_addend),
        .cin   (1'b0)
    );

    assign w_acc_top  = acc_q[WIDTH] ^ w_carry;
    assign w_prod_raw = {acc_q[WIDTH-1:0], mplier_q};
    assign w_prod     = neg_q ? (-w_prod_raw) : w_prod_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    mcand_d  = w_abs_a;
                    mplier_d = w_abs_b;
                    neg_d    = bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                    acc_d    = '0;
                    count_d  = '0;
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                // Add-then-shift of {acc, mplier} as one register.
                acc_d    = {1'b0, w_acc_top, w_sum[WIDTH-1:1]};
                mplier_d = {w_sum[0], mplier_q[WIDTH-1:1]};
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = w_prod[2*WIDTH-1:WIDTH];
                lo_d    = w_prod[WIDTH-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
`default_nettype wire
